hazard3_bus_arbiter: RTL and testbench
======================================

Name: hazard3_bus_arbiter

Overview:
- Merges the core's split-phase instruction port (suffix _i) and data port (suffix _d) onto one AHB-lite master port.
- Instantiated between the core and a single-ported SRAM/peripheral fabric.
- Arbitrates address phases with data priority and a bounded instruction-starvation guard.
- Tracks data-phase ownership so responses, read data and errors return to the right requester.

Parameters:
W_ADDR, 32, address width
W_DATA, 32, data width
MAX_D_STREAK, 4, max consecutive data grants while an instruction request waits; 0 disables the guard (pure data priority)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
bus_aph_req_i  in  1  instruction address-phase request
bus_aph_ready_i  out  1  instruction address phase accepted
bus_dph_ready_i  out  1  instruction data phase complete
bus_dph_err_i  out  1  instruction data-phase error (valid with dph_ready_i)
bus_haddr_i  in  W_ADDR  instruction address
bus_hsize_i  in  3  instruction size
bus_priv_i  in  1  instruction privileged
bus_rdata_i  out  W_DATA  instruction read data
bus_aph_req_d  in  1  data address-phase request
bus_aph_ready_d  out  1  data address phase accepted
bus_dph_ready_d  out  1  data data phase complete
bus_dph_err_d  out  1  data data-phase error
bus_haddr_d  in  W_ADDR  data address
bus_hsize_d  in  3  data size
bus_priv_d  in  1  data privileged
bus_hwrite_d  in  1  data write
bus_wdata_d  in  W_DATA  write data, presented by core during data phase
bus_rdata_d  out  W_DATA  data read data
htrans  out  2  AHB trans: 2'b00 IDLE, 2'b10 NONSEQ
haddr  out  W_ADDR  AHB address
hsize  out  3  AHB size
hwrite  out  1  AHB write
hprot  out  4  {2'b00, priv, is_data}
hwdata  out  W_DATA  AHB write data
hready  in  1  AHB ready
hresp  in  1  AHB error response
hrdata  in  W_DATA  AHB read data

Behaviour:
- State registers:
  - dph_owner {NONE, I, D}
  - aph_lock (1b) plus lock_sel (I/D)
  - d_streak counter, width clog2(MAX_D_STREAK+1)
- Reset: all state registers 0/NONE. With no requests, htrans=IDLE and all ready/err outputs 0.
- Grant selection when aph_lock=0:
  - Only one port requesting: that port wins.
  - Both requesting: D wins, unless MAX_D_STREAK>0 and d_streak==MAX_D_STREAK, in which case I wins.
- Grant selection when aph_lock=1: lock_sel wins regardless of requests. Requesters hold their request until aph_ready, so a locked address phase must never change mid-stall.
- Address-phase drive:
  - Winner drives htrans=NONSEQ with its haddr/hsize/priv.
  - hwrite = bus_hwrite_d for a D grant, 0 for an I grant.
  - hprot[0]=1 for D, 0 for I.
  - With no winner: htrans=IDLE; haddr/hsize/hwrite hold I-port values (don't-care).
- Acceptance:
  - bus_aph_ready_x = (winner==x) & hready. This is the same cycle; zero added latency.
  - On acceptance, dph_owner <= x.
  - On hready with no transfer issued, dph_owner <= NONE.
- Lock:
  - NONSEQ driven with hready=0 sets aph_lock=1 and lock_sel=winner.
  - The lock clears on the cycle hready=1.
- Streak counter:
  - Accepted D while bus_aph_req_i=1: d_streak increments, saturating at MAX_D_STREAK.
  - Accepted I, or a cycle with bus_aph_req_i=0: d_streak clears.
- Data phase:
  - bus_dph_ready_x = hready & (dph_owner==x).
  - bus_dph_err_x = hready & hresp & (dph_owner==x).
  - bus_rdata_i and bus_rdata_d both = hrdata (combinational).
  - hwdata = bus_wdata_d.
- Error cancel: in the first error cycle (hresp=1, hready=0) with aph_lock=0, htrans is forced IDLE and no aph_ready is given. A transfer already locked continues.
- Back-to-back: an address phase of one port may overlap the data phase of the other; ownership is per-phase.
- Asynchronous reset mid-transfer clears all state immediately. Outstanding phases are abandoned, and no dph_ready is produced after reset.

Test Plan:
- I-only fetches at 0x0,0x4,0x8 with hready=1: htrans=NONSEQ each cycle, aph_ready_i=1, dph_ready_i one cycle later, rdata_i=hrdata, hprot=4'b0010 (priv=1).
- Both requesting continuously, MAX_D_STREAK=4, hready=1: grant pattern D,D,D,D,I repeating. With MAX_D_STREAK=0: all D until bus_aph_req_d drops.
- I granted, hready=0 for 3 cycles while D starts requesting: haddr and htrans stay on the I address; D is granted only after hready=1.
- D write 0xDEADBEEF to 0x20 followed by I fetch: hwrite=1 in the D address phase; hwdata=0xDEADBEEF during the D data phase while the I address phase is on the bus; dph_ready goes to D, then to I.
- D read gets two-cycle error (hresp=1/hready=0, then hresp=1/hready=1): a pending unlocked I request sees htrans=IDLE in cycle 1; bus_dph_err_d=1 and bus_dph_ready_d=1 in cycle 2; bus_dph_err_i stays 0.
- Assert rst_n=0 during a stalled D data phase: dph_owner=NONE, d_streak=0, no dph_ready asserted; after release with no requests, htrans=IDLE.

Source files
------------

// File: rtl/hazard3_bus_arbiter_if.sv
// ==== hazard3_bus_arbiter_if : core I/D split-phase ports plus the merged AHB-lite master port ==== Rev 1.0
`default_nettype none

interface hazard3_bus_arbiter_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic              bus_aph_req_i;
  logic              bus_aph_ready_i;
  logic              bus_dph_ready_i;
  logic              bus_dph_err_i;
  logic [W_ADDR-1:0] bus_haddr_i;
  logic [2:0]        bus_hsize_i;
  logic              bus_priv_i;
  logic [W_DATA-1:0] bus_rdata_i;

  logic              bus_aph_req_d;
  logic              bus_aph_ready_d;
  logic              bus_dph_ready_d;
  logic              bus_dph_err_d;
  logic [W_ADDR-1:0] bus_haddr_d;
  logic [2:0]        bus_hsize_d;
  logic              bus_priv_d;
  logic              bus_hwrite_d;
  logic [W_DATA-1:0] bus_wdata_d;
  logic [W_DATA-1:0] bus_rdata_d;

  logic [1:0]        htrans;
  logic [W_ADDR-1:0] haddr;
  logic [2:0]        hsize;
  logic              hwrite;
  logic [3:0]        hprot;
  logic [W_DATA-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [W_DATA-1:0] hrdata;

  // Arbiter view: it is the AHB master towards the fabric.
  modport master (
    input  bus_aph_req_i, bus_haddr_i, bus_hsize_i, bus_priv_i,
    output bus_aph_ready_i, bus_dph_ready_i, bus_dph_err_i, bus_rdata_i,
    input  bus_aph_req_d, bus_haddr_d, bus_hsize_d, bus_priv_d, bus_hwrite_d, bus_wdata_d,
    output bus_aph_ready_d, bus_dph_ready_d, bus_dph_err_d, bus_rdata_d,
    output htrans, haddr, hsize, hwrite, hprot, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    output bus_aph_req_i, bus_haddr_i, bus_hsize_i, bus_priv_i,
    input  bus_aph_ready_i, bus_dph_ready_i, bus_dph_err_i, bus_rdata_i,
    output bus_aph_req_d, bus_haddr_d, bus_hsize_d, bus_priv_d, bus_hwrite_d, bus_wdata_d,
    input  bus_aph_ready_d, bus_dph_ready_d, bus_dph_err_d, bus_rdata_d,
    input  htrans, haddr, hsize, hwrite, hprot, hwdata,
    output hready, hresp, hrdata
  );
endinterface

`default_nettype wire

// File: rtl/hazard3_bus_arbiter.sv
// ==== hazard3_bus_arbiter : I/D to single AHB-lite arbiter, data priority with starvation guard ==== Rev 1.0
`default_nettype none

module hazard3_bus_arbiter #(
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  hazard3_bus_arbiter_if.master bus
);

  localparam int W_STREAK = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [W_STREAK-1:0] STREAK_MAX    = W_STREAK'(MAX_D_STREAK);
  localparam logic [1:0]          HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]          HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_t;

  owner_t                dph_owner_q, dph_owner_d;
  logic                  aph_lock_q, aph_lock_d;
  logic                  lock_sel_q, lock_sel_d;   // 1: D holds the lock, 0: I
  logic [W_STREAK-1:0]   d_streak_q, d_streak_d;

  logic                  grant_i, grant_d;
  logic                  err_cancel, streak_full;
  logic [W_ADDR-1:0]     haddr_sel;
  logic [W_DATA-1:0]     rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph_owner_q <= OWNER_NONE;
      aph_lock_q  <= 1'b0;
      lock_sel_q  <= 1'b0;
      d_streak_q  <= '0;
    end else begin
      dph_owner_q <= dph_owner_d;
      aph_lock_q  <= aph_lock_d;
      lock_sel_q  <= lock_sel_d;
      d_streak_q  <= d_streak_d;
    end
  end

  // A stalled address phase keeps its owner; a fresh error stall suppresses new issue.
  always_comb begin
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    err_cancel  = bus.hresp & ~bus.hready & ~aph_lock_q;
    streak_full = (MAX_D_STREAK > 0) && (d_streak_q == STREAK_MAX);
    if (aph_lock_q) begin
      grant_d = lock_sel_q;
      grant_i = ~lock_sel_q;
    end else if (!err_cancel) begin
      if (bus.bus_aph_req_d && !(bus.bus_aph_req_i && streak_full))
        grant_d = 1'b1;
      else if (bus.bus_aph_req_i)
        grant_i = 1'b1;
    end
  end

  always_comb begin
    dph_owner_d = dph_owner_q;
    aph_lock_d  = aph_lock_q;
    lock_sel_d  = lock_sel_q;
    d_streak_d  = d_streak_q;
    if (bus.hready) begin
      aph_lock_d  = 1'b0;
      dph_owner_d = grant_d ? OWNER_D : (grant_i ? OWNER_I : OWNER_NONE);
    end else if (grant_i || grant_d) begin
      aph_lock_d = 1'b1;
      lock_sel_d = grant_d;
    end
    if (!bus.bus_aph_req_i || (grant_i && bus.hready))
      d_streak_d = '0;
    else if (grant_d && bus.hready && (d_streak_q != STREAK_MAX))
      d_streak_d = d_streak_q + 1'b1;
  end

  assign haddr_sel           = grant_d ? bus.bus_haddr_d : bus.bus_haddr_i;
  assign bus.htrans          = (grant_i || grant_d) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.haddr           = haddr_sel;
  assign bus.hsize           = grant_d ? bus.bus_hsize_d : bus.bus_hsize_i;
  assign bus.hwrite          = grant_d & bus.bus_hwrite_d;
  assign bus.hprot           = {2'b00, (grant_d ? bus.bus_priv_d : bus.bus_priv_i), grant_d};
  assign bus.hwdata          = bus.bus_wdata_d;

  assign bus.bus_aph_ready_i = grant_i & bus.hready;
  assign bus.bus_aph_ready_d = grant_d & bus.hready;

  assign bus.bus_dph_ready_i = bus.hready & (dph_owner_q == OWNER_I);
  assign bus.bus_dph_ready_d = bus.hready & (dph_owner_q == OWNER_D);
  assign bus.bus_dph_err_i   = bus.hready & bus.hresp & (dph_owner_q == OWNER_I);
  assign bus.bus_dph_err_d   = bus.hready & bus.hresp & (dph_owner_q == OWNER_D);

  assign rdata               = bus.hrdata;
  assign bus.bus_rdata_i     = rdata;
  assign bus.bus_rdata_d     = rdata;

endmodule

`default_nettype wire

// File: tb/tb_hazard3_bus_arbiter.sv
// ==== tb_hazard3_bus_arbiter : directed + random checks of two arbiter instances (MAX_D_STREAK 4 and 0) ==== Rev 1.0
`default_nettype none

module tb_hazard3_bus_arbiter;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;
  localparam int MX [2] = '{4, 0};

  logic clk;
  logic rst_n;

  logic              req_i, req_d, priv_i, priv_d, hwrite_d, hready, hresp;
  logic [W_ADDR-1:0] haddr_i, haddr_d;
  logic [2:0]        hsize_i, hsize_d;
  logic [W_DATA-1:0] wdata_d, hrdata;

  logic [1:0]        o_htrans   [2];
  logic [W_ADDR-1:0] o_haddr    [2];
  logic [2:0]        o_hsize    [2];
  logic              o_hwrite   [2];
  logic [3:0]        o_hprot    [2];
  logic [W_DATA-1:0] o_hwdata   [2];
  logic              o_aready_i [2];
  logic              o_aready_d [2];
  logic              o_dready_i [2];
  logic              o_dready_d [2];
  logic              o_err_i    [2];
  logic              o_err_d    [2];
  logic [W_DATA-1:0] o_rdata_i  [2];
  logic [W_DATA-1:0] o_rdata_d  [2];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 0 = nobody, 1 = I port, 2 = D port.
  int m_owner     [2];
  int m_locked    [2];
  int m_lock_port [2];
  int m_streak    [2];
  int m_g         [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    hazard3_bus_arbiter_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bif ();
    assign bif.bus_aph_req_i = req_i;
    assign bif.bus_haddr_i   = haddr_i;
    assign bif.bus_hsize_i   = hsize_i;
    assign bif.bus_priv_i    = priv_i;
    assign bif.bus_aph_req_d = req_d;
    assign bif.bus_haddr_d   = haddr_d;
    assign bif.bus_hsize_d   = hsize_d;
    assign bif.bus_priv_d    = priv_d;
    assign bif.bus_hwrite_d  = hwrite_d;
    assign bif.bus_wdata_d   = wdata_d;
    assign bif.hready        = hready;
    assign bif.hresp         = hresp;
    assign bif.hrdata        = hrdata;

    hazard3_bus_arbiter #(
      .W_ADDR(W_ADDR), .W_DATA(W_DATA), .MAX_D_STREAK(MX[k])
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.master)
    );

    assign o_htrans[k]   = bif.htrans;
    assign o_haddr[k]    = bif.haddr;
    assign o_hsize[k]    = bif.hsize;
    assign o_hwrite[k]   = bif.hwrite;
    assign o_hprot[k]    = bif.hprot;
    assign o_hwdata[k]   = bif.hwdata;
    assign o_aready_i[k] = bif.bus_aph_ready_i;
    assign o_aready_d[k] = bif.bus_aph_ready_d;
    assign o_dready_i[k] = bif.bus_dph_ready_i;
    assign o_dready_d[k] = bif.bus_dph_ready_d;
    assign o_err_i[k]    = bif.bus_dph_err_i;
    assign o_err_d[k]    = bif.bus_dph_err_d;
    assign o_rdata_i[k]  = bif.bus_rdata_i;
    assign o_rdata_d[k]  = bif.bus_rdata_d;
  end

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0; m_locked[k] = 0; m_lock_port[k] = 0; m_streak[k] = 0; m_g[k] = 0;
    end
  endtask

  function automatic int exp_grant(input int k);
    if (m_locked[k] != 0)            return m_lock_port[k];
    if (hresp && !hready)            return 0;
    if (req_i && req_d)              return (MX[k] > 0 && m_streak[k] == MX[k]) ? 1 : 2;
    if (req_d)                       return 2;
    if (req_i)                       return 1;
    return 0;
  endfunction

  task automatic settle();
    int g;
    #1;
    for (int k = 0; k < 2; k++) begin
      g = exp_grant(k);
      m_g[k] = g;
      chk("htrans",   k, o_htrans[k],   (g != 0) ? 2 : 0);
      chk("haddr",    k, o_haddr[k],    (g == 2) ? haddr_d : haddr_i);
      chk("hsize",    k, o_hsize[k],    (g == 2) ? hsize_d : hsize_i);
      chk("hwrite",   k, o_hwrite[k],   (g == 2) && hwrite_d);
      chk("hprot",    k, o_hprot[k],    {2'b00, (g == 2) ? priv_d : priv_i, g == 2});
      chk("hwdata",   k, o_hwdata[k],   wdata_d);
      chk("aready_i", k, o_aready_i[k], (g == 1) && hready);
      chk("aready_d", k, o_aready_d[k], (g == 2) && hready);
      chk("dready_i", k, o_dready_i[k], hready && m_owner[k] == 1);
      chk("dready_d", k, o_dready_d[k], hready && m_owner[k] == 2);
      chk("err_i",    k, o_err_i[k],    hready && hresp && m_owner[k] == 1);
      chk("err_d",    k, o_err_d[k],    hready && hresp && m_owner[k] == 2);
      chk("rdata_i",  k, o_rdata_i[k],  hrdata);
      chk("rdata_d",  k, o_rdata_d[k],  hrdata);
    end
  endtask

  task automatic tick();
    int g;
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        g = m_g[k];
        if (!req_i)                                            m_streak[k] = 0;
        else if (hready && g == 1)                             m_streak[k] = 0;
        else if (hready && g == 2 && m_streak[k] < MX[k])      m_streak[k]++;
        if (hready) begin
          m_owner[k]  = g;
          m_locked[k] = 0;
        end else if (g != 0) begin
          m_locked[k]    = 1;
          m_lock_port[k] = g;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    req_i = 0; req_d = 0; priv_i = 0; priv_d = 0; hwrite_d = 0;
    haddr_i = '0; haddr_d = '0; hsize_i = 3'd2; hsize_d = 3'd2;
    wdata_d = '0; hready = 1; hresp = 0; hrdata = 32'h1234_5678;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    settle();
    chk("rst_htrans", 0, o_htrans[0], 2'b00);
    chk("rst_dready", 0, o_dready_d[0], 1'b0);
    tick();
    step();
    rst_n = 1'b1;
    step();

    // Instruction fetches 0x0, 0x4, 0x8, privileged
    priv_i = 1; req_i = 1;
    for (int a = 0; a < 3; a++) begin
      haddr_i = 32'(a * 4);
      hrdata  = $urandom;
      settle();
      chk("fetch_hprot",  0, o_hprot[0], 4'b0010);
      chk("fetch_aready", 0, o_aready_i[0], 1'b1);
      if (a > 0) chk("fetch_dready", 0, o_dready_i[0], 1'b1);
      tick();
    end
    req_i = 0; priv_i = 0;
    settle();
    chk("fetch_last_dready", 0, o_dready_i[0], 1'b1);
    tick();

    // Continuous contention: D,D,D,D,I with guard; all D without
    req_i = 1; req_d = 1;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("pattern_guard", 0, o_hprot[0][0], (c % 5) != 4);
      chk("pattern_nog",   1, o_hprot[1][0], 1'b1);
      tick();
    end
    req_d = 0;
    settle();
    chk("pattern_nog_i", 1, o_hprot[1][0], 1'b0);
    chk("pattern_nog_t", 1, o_htrans[1], 2'b10);
    tick();
    req_i = 0;
    step();

    // Stalled I address phase must hold while D starts requesting
    req_i = 1; haddr_i = 32'h100; hready = 0;
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) begin req_d = 1; haddr_d = 32'h200; end
      settle();
      chk("stall_haddr",  0, o_haddr[0], 32'h100);
      chk("stall_htrans", 0, o_htrans[0], 2'b10);
      tick();
    end
    hready = 1;
    settle();
    chk("stall_aready_i", 0, o_aready_i[0], 1'b1);
    chk("stall_aready_d", 0, o_aready_d[0], 1'b0);
    tick();
    req_i = 0;
    settle();
    chk("stall_then_d", 0, o_aready_d[0], 1'b1);
    chk("stall_d_addr", 0, o_haddr[0], 32'h200);
    tick();
    req_d = 0;
    step();

    // D write then I fetch overlapping its data phase
    req_d = 1; hwrite_d = 1; haddr_d = 32'h20;
    settle();
    chk("wr_hwrite", 0, o_hwrite[0], 1'b1);
    chk("wr_aready", 0, o_aready_d[0], 1'b1);
    tick();
    req_d = 0; hwrite_d = 0; wdata_d = 32'hDEADBEEF; req_i = 1; haddr_i = 32'h40;
    settle();
    chk("wr_hwdata",   0, o_hwdata[0], 32'hDEADBEEF);
    chk("wr_dready_d", 0, o_dready_d[0], 1'b1);
    chk("wr_i_addr",   0, o_haddr[0], 32'h40);
    tick();
    req_i = 0;
    settle();
    chk("wr_dready_i", 0, o_dready_i[0], 1'b1);
    chk("wr_dready_d2", 0, o_dready_d[0], 1'b0);
    tick();

    // Two-cycle error on a D read with an I request pending
    req_d = 1; haddr_d = 32'h30;
    step();
    req_d = 0; req_i = 1; haddr_i = 32'h50; hresp = 1; hready = 0;
    settle();
    chk("err_cancel_htrans", 0, o_htrans[0], 2'b00);
    chk("err_cancel_aready", 0, o_aready_i[0], 1'b0);
    tick();
    hready = 1;
    settle();
    chk("err_d",      0, o_err_d[0], 1'b1);
    chk("err_dready", 0, o_dready_d[0], 1'b1);
    chk("err_i",      0, o_err_i[0], 1'b0);
    tick();
    hresp = 0; req_i = 0;
    step();

    // Reset during a stalled D data phase with a nonzero streak
    req_i = 1; req_d = 1; haddr_d = 32'h60;
    step();
    step();
    hready = 0;
    step();
    rst_n = 0; req_i = 0; req_d = 0; hready = 1;
    model_reset();
    settle();
    chk("rstmid_dready_d", 0, o_dready_d[0], 1'b0);
    chk("rstmid_dready_i", 0, o_dready_i[0], 1'b0);
    tick();
    rst_n = 1;
    settle();
    chk("rstmid_idle", 0, o_htrans[0], 2'b00);
    tick();
    req_i = 1; req_d = 1;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("rst_streak_clear", 0, o_hprot[0][0], c != 4);
      tick();
    end
    idle_inputs();
    step();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      req_i    = ($urandom_range(0, 3) != 0);
      req_d    = ($urandom_range(0, 1) != 0);
      haddr_i  = $urandom;
      haddr_d  = $urandom;
      hsize_i  = 3'($urandom_range(0, 7));
      hsize_d  = 3'($urandom_range(0, 7));
      priv_i   = 1'($urandom_range(0, 1));
      priv_d   = 1'($urandom_range(0, 1));
      hwrite_d = 1'($urandom_range(0, 1));
      wdata_d  = $urandom;
      hrdata   = $urandom;
      hready   = ($urandom_range(0, 3) != 0);
      hresp    = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
